// File: rtl/knight_uart_cmd_port.sv
// ---------------------------------------------------------------------------
// knight_uart_cmd_port
//   Knight-side end of the RemoteComm serial link. An 8N1 UART receiver feeds
//   a two-byte command assembler (high byte first) that hands 16-bit commands
//   to cmd_proc. An 8N1 transmitter returns the one-byte response.
//
// Parameters
//   BAUD_DIV     clk cycles per serial bit (>= 16, < 8192)
//   TIMEOUT_CYC  max clk cycles allowed between high and low command byte
//                (used only when KNT_BYTE_TIMEOUT_EN is defined)
//
// Configuration macro
//   KNT_BYTE_TIMEOUT_EN  when defined, a lone high byte is dropped after
//                        TIMEOUT_CYC cycles without a low byte. When undefined,
//                        no counter exists and the low byte is awaited forever.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   RX           in   serial input (asynchronous, idles high)
//   TX           out  serial output (idles high)
//   cmd          out  last assembled command {hi,lo}
//   cmd_rdy      out  level, a new command is valid
//   clr_cmd_rdy  in   consumer acknowledge, clears cmd_rdy
//   resp         in   response byte to transmit
//   trmt         in   one-cycle strobe, start transmitting resp
//   tx_done      out  one-cycle pulse after the stop bit of resp
//   frm_err      out  one-cycle pulse when a received stop bit reads 0
// ---------------------------------------------------------------------------
module knight_uart_cmd_port #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frm_err
);

    localparam int              CNT_W     = 13;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    // -----------------------------------------------------------------------
    // RX synchroniser; the third flop remembers the previous synchronised
    // level so a start bit is recognised only on a genuine 1->0 transition.
    // -----------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign rx_fall = rx_s3_q & ~rx_s2_q;

    // -----------------------------------------------------------------------
    // RX bit FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             rx_rdy;
    logic             frm_err_q, frm_err_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_rdy     = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = '0;
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_rdy     = rx_s2_q;
                    frm_err_d  = ~rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            frm_err_q  <= frm_err_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh_q <= rx_sh_d;
    end

    // -----------------------------------------------------------------------
    // Command assembly
    // -----------------------------------------------------------------------
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    asm_state_t  asm_q, asm_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

`ifdef KNT_BYTE_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Runs only while a high byte is pending; any valid byte restarts it.
    always_comb begin
        to_cnt_d = '0;
        if (asm_q == WAIT_LO && !rx_rdy) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_comb begin
        asm_d     = asm_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        // Byte handling comes after the acknowledge so a set overrides it.
        case (asm_q)
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_d      = rx_sh_q;
                    asm_d     = WAIT_LO;
                    cmd_rdy_d = 1'b0;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    cmd_d     = {hi_q, rx_sh_q};
                    cmd_rdy_d = 1'b1;
                    asm_d     = WAIT_HI;
                end
`ifdef KNT_BYTE_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    asm_d = WAIT_HI;
                end
`endif
            end
            default: asm_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q     <= WAIT_HI;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    // -----------------------------------------------------------------------
    // TX FSM; the frame {stop, data, start} is shifted out LSB first and the
    // line level is registered from the next-state values to avoid glitches.
    // -----------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [9:0]       tx_sh_q, tx_sh_d;
    logic             tx_q, tx_d;
    logic             tx_done_q, tx_done_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_sh_d    = {1'b1, resp, 1'b0};
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_d = (tx_state_d == TX_XMIT) ? tx_sh_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q <= tx_sh_d;
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;
    assign frm_err = frm_err_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule
